nrx_psg_mux: RTL and testbench
==============================

NRX_PSG_MUX -- requirements
Module: nrx_psg_mux

Interface
Parameters (one per line: name, default, meaning):
- REQ-001 SHALL provide NVOICE, 3, number of time-multiplexed voices, legal range 1..8.
- REQ-002 SHALL provide ACC_W, 20, phase accumulator and frequency width.
- REQ-003 SHALL provide WSEL_W, 3, waveform select width.
- REQ-004 SHALL provide WLEN_W, 5, waveform step index width, taken from the accumulator MSBs.
- REQ-005 SHALL provide WAVE_W, 4, wave sample and volume width.
- REQ-006 SHALL define local OUT_W = WAVE_W + clog2(NVOICE), or WAVE_W when NVOICE = 1.

Ports (one per line: name direction width meaning):
- REQ-007 SHALL have clk, in, 1: the single clock; all state changes on its rising edge.
- REQ-008 SHALL have reset, in, 1: synchronous, active-high reset.
- REQ-009 SHALL have tick, in, 1: sample-rate enable that starts one mixing pass.
- REQ-010 SHALL have wr_en, in, 1: voice register write strobe.
- REQ-011 SHALL have wr_voice, in, 3: target voice index; writes with index >= NVOICE are ignored.
- REQ-012 SHALL have wr_freq in ACC_W, wr_vol in WAVE_W, and wr_wsel in WSEL_W: write data.
- REQ-013 SHALL have waveaddr, out, WSEL_W+WLEN_W: wave ROM address, equal to {wsel[v], acc[v][ACC_W-1 -: WLEN_W]}.
- REQ-014 SHALL have wavedata, in, WAVE_W: ROM data, valid exactly one cycle after waveaddr.
- REQ-015 SHALL have out, out, OUT_W: mixed sample, held between passes.
- REQ-016 SHALL have out_valid, out, 1: one-cycle pulse when out updates.
- REQ-017 SHALL have busy, out, 1: high while a pass is in progress.
- REQ-018 SHALL have overrun, out, 1: sticky flag set when a tick is lost.

Function
- REQ-019 SHALL hold per-voice freq, vol, wsel and acc registers, each NVOICE deep.
- REQ-020 SHALL implement FSM states IDLE, FETCH and DRAIN: IDLE+tick -> FETCH with idx=0; FETCH with idx=NVOICE-1 -> DRAIN; DRAIN -> IDLE.
- REQ-021 SHALL, in each FETCH cycle, present waveaddr for voice idx, update acc[idx] <= acc[idx] + freq[idx] modulo 2^ACC_W, and increment idx.
- REQ-022 SHALL, in each cycle after a FETCH, add (wavedata * vol[v])[2*WAVE_W-1 -: WAVE_W] to the mix accumulator, where v is the voice fetched in the previous cycle.
- REQ-023 SHALL clear the mix accumulator on the entry to FETCH.
- REQ-024 SHALL, in the cycle after DRAIN, load out with the complete sum and pulse out_valid; latency from the tick cycle to out_valid is NVOICE+2 cycles.
- REQ-025 SHALL drive busy high from the cycle after the tick through the out_valid cycle inclusive.
- REQ-026 SHALL ignore any tick that arrives while busy is high, and set overrun, which stays set until reset.
- REQ-027 SHALL accept register writes in any state without stalling the pass.
- REQ-028 SHALL, when a write targets voice v in the same cycle that v is fetched, use the old freq/vol/wsel for that pass, with the new value stored for the next pass.
- REQ-029 SHALL never let a write modify acc.
- REQ-030 SHALL keep accumulators advancing when vol=0 (a silent voice keeps its phase).
- REQ-031 SHALL let the accumulator wrap silently, with no carry-out used.
- REQ-032 SHALL never saturate the mix, because OUT_W guarantees no overflow.
- REQ-033 SHALL hold waveaddr at the last fetched address outside FETCH.

Reset
- REQ-034 SHALL, on reset, clear all freq, vol, wsel and acc entries plus out, out_valid, busy, overrun, idx and the mix accumulator to 0, and set the FSM to IDLE.
- REQ-035 SHALL, on reset asserted mid-pass, abort the pass with no out_valid pulse; the first tick after reset deasserts starts a fresh pass.
- REQ-036 SHALL give reset priority over a simultaneous tick or wr_en.

Verification
- REQ-037 SHALL cover single voice: NVOICE=3, voice0 freq=0x08000, vol=0xF, wsel=2, ROM returning addr[3:0]; tick -> waveaddr sequence 0x40,0x00,0x00, out=0 on first pass; the second pass gives waveaddr 0x41 and out=(1*15)>>4=0.
- REQ-038 SHALL cover full-scale mix: all three voices with vol=0xF and ROM constant 0xF; tick in cycle 0 -> out_valid in cycle 5 with out=3*14=42; busy high in cycles 1..5.
- REQ-039 SHALL cover overrun: a tick in cycle 0 and a second tick in cycle 2 -> a single out_valid in cycle 5 and overrun=1 from cycle 3 onward.
- REQ-040 SHALL cover accumulator wrap: freq=0xFFFFF, 2 passes -> acc=0xFFFFE with no error.
- REQ-041 SHALL cover write collision: a wr_en to voice1 with vol=0 in voice1's FETCH cycle -> the current pass still includes voice1 and the next pass excludes it.
- REQ-042 SHALL cover mid-pass reset: reset in cycle 3 of a pass -> no out_valid, all outputs 0, and a later tick produces a normal pass.

Source files
------------

// File: rtl/nrx_psg_mux.sv
// Time-multiplexed wavetable voice mixer: each tick starts one pass that fetches every
// voice from an external synchronous wave ROM and sums the volume-scaled samples.
module nrx_psg_mux #(
    parameter int NVOICE = 3,
    parameter int ACC_W  = 20,
    parameter int WSEL_W = 3,
    parameter int WLEN_W = 5,
    parameter int WAVE_W = 4,
    localparam int OUT_W = (NVOICE > 1) ? WAVE_W + $clog2(NVOICE) : WAVE_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     tick,
    input  logic                     wr_en,
    input  logic [2:0]               wr_voice,
    input  logic [ACC_W-1:0]         wr_freq,
    input  logic [WAVE_W-1:0]        wr_vol,
    input  logic [WSEL_W-1:0]        wr_wsel,
    output logic [WSEL_W+WLEN_W-1:0] waveaddr,
    input  logic [WAVE_W-1:0]        wavedata,
    output logic [OUT_W-1:0]         out,
    output logic                     out_valid,
    output logic                     busy,
    output logic                     overrun
);

    localparam int IDX_W = (NVOICE > 1) ? $clog2(NVOICE) : 1;
    localparam int AW    = WSEL_W + WLEN_W;
    localparam int PW    = 2 * WAVE_W;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic [WAVE_W-1:0]  fvol_q, fvol_d;
    logic               pend_q, pend_d;
    logic [OUT_W-1:0]   mix_q, mix_d;
    logic [OUT_W-1:0]   out_q, out_d;
    logic               out_valid_q, out_valid_d;
    logic               overrun_q, overrun_d;

    logic [ACC_W-1:0]   freq_q [NVOICE];
    logic [ACC_W-1:0]   freq_d [NVOICE];
    logic [ACC_W-1:0]   acc_q  [NVOICE];
    logic [ACC_W-1:0]   acc_d  [NVOICE];
    logic [WAVE_W-1:0]  vol_q  [NVOICE];
    logic [WAVE_W-1:0]  vol_d  [NVOICE];
    logic [WSEL_W-1:0]  wsel_q [NVOICE];
    logic [WSEL_W-1:0]  wsel_d [NVOICE];

    logic [AW-1:0]      cur_addr;
    logic [WAVE_W-1:0]  cur_vol;
    logic [PW-1:0]      prod;
    logic [OUT_W-1:0]   contrib;
    logic               busy_w;

    // Per-voice register bank. Fetch reads the _q values, so a write landing in the
    // same cycle as that voice's fetch only takes effect on the next pass.
    for (genvar gi = 0; gi < NVOICE; gi++) begin : g_voice
        logic wr_hit;
        logic fetch_hit;

        assign wr_hit     = wr_en && (wr_voice == 3'(gi));
        assign fetch_hit  = (state_q == FETCH) && (idx_q == IDX_W'(gi));
        assign freq_d[gi] = wr_hit ? wr_freq : freq_q[gi];
        assign vol_d[gi]  = wr_hit ? wr_vol : vol_q[gi];
        assign wsel_d[gi] = wr_hit ? wr_wsel : wsel_q[gi];
        assign acc_d[gi]  = fetch_hit ? acc_q[gi] + freq_q[gi] : acc_q[gi];

        always_ff @(posedge clk) begin
            if (reset) begin
                freq_q[gi] <= '0;
                vol_q[gi]  <= '0;
                wsel_q[gi] <= '0;
                acc_q[gi]  <= '0;
            end else begin
                freq_q[gi] <= freq_d[gi];
                vol_q[gi]  <= vol_d[gi];
                wsel_q[gi] <= wsel_d[gi];
                acc_q[gi]  <= acc_d[gi];
            end
        end
    end

    always_comb begin
        cur_addr = '0;
        cur_vol  = '0;
        for (int v = 0; v < NVOICE; v++) begin
            if (idx_q == IDX_W'(v)) begin
                cur_addr = {wsel_q[v], acc_q[v][ACC_W-1 -: WLEN_W]};
                cur_vol  = vol_q[v];
            end
        end
    end

    // The ROM answers one cycle after the address, so the volume is captured at fetch
    // time and applied to wavedata in the following cycle.
    assign prod    = PW'(wavedata) * PW'(fvol_q);
    assign contrib = pend_q ? OUT_W'(prod[PW-1 -: WAVE_W]) : '0;
    assign busy_w  = (state_q != IDLE) || out_valid_q;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        addr_d      = addr_q;
        fvol_d      = fvol_q;
        pend_d      = 1'b0;
        mix_d       = mix_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        overrun_d   = overrun_q;

        if (tick && busy_w) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (tick && !out_valid_q) begin
                    state_d = FETCH;
                    idx_d   = '0;
                    mix_d   = '0;
                end
            end
            FETCH: begin
                addr_d = cur_addr;
                fvol_d = cur_vol;
                pend_d = 1'b1;
                mix_d  = mix_q + contrib;
                if (idx_q == IDX_W'(NVOICE - 1)) begin
                    state_d = DRAIN;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DRAIN: begin
                mix_d       = mix_q + contrib;
                out_d       = mix_q + contrib;
                out_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            addr_q      <= '0;
            fvol_q      <= '0;
            pend_q      <= 1'b0;
            mix_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            addr_q      <= addr_d;
            fvol_q      <= fvol_d;
            pend_q      <= pend_d;
            mix_q       <= mix_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign waveaddr  = (state_q == FETCH) ? cur_addr : addr_q;
    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_w;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_nrx_psg_mux.sv
// Bench for nrx_psg_mux: directed vector table, hand-written corner sequences and a
// randomized run, all shadowed every cycle by a pass-level reference model.
module tb_nrx_psg_mux;

    localparam int NVOICE = 3;
    localparam int ACC_W  = 20;
    localparam int WSEL_W = 3;
    localparam int WLEN_W = 5;
    localparam int WAVE_W = 4;
    localparam int OUT_W  = 6;

    logic              clk = 1'b0;
    logic              reset, tick, wr_en;
    logic [2:0]        wr_voice;
    logic [ACC_W-1:0]  wr_freq;
    logic [WAVE_W-1:0] wr_vol;
    logic [WSEL_W-1:0] wr_wsel;
    logic [7:0]        waveaddr;
    logic [WAVE_W-1:0] wavedata;
    logic [OUT_W-1:0]  out;
    logic              out_valid, busy, overrun;

    nrx_psg_mux #(
        .NVOICE(NVOICE), .ACC_W(ACC_W), .WSEL_W(WSEL_W), .WLEN_W(WLEN_W), .WAVE_W(WAVE_W)
    ) dut (
        .clk(clk), .reset(reset), .tick(tick), .wr_en(wr_en), .wr_voice(wr_voice),
        .wr_freq(wr_freq), .wr_vol(wr_vol), .wr_wsel(wr_wsel), .waveaddr(waveaddr),
        .wavedata(wavedata), .out(out), .out_valid(out_valid), .busy(busy),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Wave ROM: 0 = low nibble of address, 1 = constant, 2 = random table.
    int         rom_mode  = 0;
    logic [3:0] rom_const = 4'h0;
    logic [3:0] rom_tab [256];

    function automatic logic [3:0] rom_f(input logic [7:0] a);
        case (rom_mode)
            0:       return a[3:0];
            1:       return rom_const;
            default: return rom_tab[a];
        endcase
    endfunction

    always @(posedge clk) wavedata <= rom_f(waveaddr);

    // Reference model: voice registers plus a description of the pass in flight.
    logic [19:0] m_freq [NVOICE];
    logic [19:0] m_acc  [NVOICE];
    logic [3:0]  m_vol  [NVOICE];
    logic [2:0]  m_wsel [NVOICE];
    bit          m_active;
    int          m_start;
    int          m_sum;
    logic [5:0]  m_out;
    bit          m_valid;
    bit          m_ovr;
    logic [7:0]  m_addr;

    function automatic logic [7:0] m_addr_of(input int v);
        return {m_wsel[v], m_acc[v][19:15]};
    endfunction

    task automatic m_reset();
        for (int v = 0; v < NVOICE; v++) begin
            m_freq[v] = '0; m_acc[v] = '0; m_vol[v] = '0; m_wsel[v] = '0;
        end
        m_active = 0; m_start = 0; m_sum = 0; m_out = '0;
        m_valid = 0; m_ovr = 0; m_addr = '0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", name, cyc, act, exp);
        end
    endtask

    // One clock cycle: compare outputs with the model, drive inputs, advance the model.
    task automatic step(input bit r, input bit t, input bit we, input logic [2:0] wv,
                        input logic [19:0] wf, input logic [3:0] wvo, input logic [2:0] ws);
        bit         fetching, bsy;
        int         v;
        logic [7:0] a;
        logic [7:0] exp_addr;
        fetching = m_active && (cyc >= m_start + 1) && (cyc <= m_start + NVOICE);
        bsy      = m_active && (cyc >= m_start + 1) && (cyc <= m_start + NVOICE + 2);
        exp_addr = fetching ? m_addr_of(cyc - m_start - 1) : m_addr;
        chk("m_waveaddr", 32'(waveaddr), 32'(exp_addr));
        chk("m_busy", 32'(busy), 32'(bsy));
        chk("m_out_valid", 32'(out_valid), 32'(m_valid));
        chk("m_out", 32'(out), 32'(m_out));
        chk("m_overrun", 32'(overrun), 32'(m_ovr));
        if (out_valid === 1'b1) $display("cycle %0d pass complete out=%0d", cyc, out);

        reset = r; tick = t; wr_en = we; wr_voice = wv;
        wr_freq = wf; wr_vol = wvo; wr_wsel = ws;

        m_valid = 0;
        if (r) begin
            m_reset();
        end else begin
            if (fetching) begin
                v = cyc - m_start - 1;
                a = m_addr_of(v);
                m_sum += (int'(rom_f(a)) * int'(m_vol[v])) / 16;
                m_acc[v] = m_acc[v] + m_freq[v];
                m_addr = a;
            end
            if (m_active && cyc == m_start + NVOICE + 1) begin
                m_out = 6'(m_sum);
                m_valid = 1;
            end
            if (m_active && cyc == m_start + NVOICE + 2) m_active = 0;
            if (t) begin
                if (bsy) m_ovr = 1;
                else begin m_active = 1; m_start = cyc; m_sum = 0; end
            end
            if (we && wv < NVOICE) begin
                m_freq[wv] = wf; m_vol[wv] = wvo; m_wsel[wv] = ws;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 3'd0, 20'h0, 4'h0, 3'd0);
    endtask

    task automatic do_reset();
        step(1, 0, 0, 3'd0, 20'h0, 4'h0, 3'd0);
    endtask

    task automatic wr(input logic [2:0] v, input logic [19:0] f, input logic [3:0] vo,
                      input logic [2:0] ws);
        step(0, 0, 1, v, f, vo, ws);
    endtask

    task automatic do_tick();
        step(0, 1, 0, 3'd0, 20'h0, 4'h0, 3'd0);
    endtask

    task automatic wait_valid(input int t0, output int lat);
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            if (out_valid === 1'b1) begin
                lat = cyc - t0;
                break;
            end
            idle(1);
        end
    endtask

    typedef struct {
        logic [2:0][3:0] vol;
        int              rmode;
        logic [3:0]      rconst;
        logic [5:0]      exp_out;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int t0, lat, nv, vc;

        vecs[0].vol = {4'hF, 4'hF, 4'hF}; vecs[0].rmode = 1; vecs[0].rconst = 4'hF; vecs[0].exp_out = 6'd42;
        vecs[1].vol = {4'h8, 4'h8, 4'h8}; vecs[1].rmode = 1; vecs[1].rconst = 4'hF; vecs[1].exp_out = 6'd21;
        vecs[2].vol = {4'h1, 4'h0, 4'hF}; vecs[2].rmode = 1; vecs[2].rconst = 4'hF; vecs[2].exp_out = 6'd14;
        vecs[3].vol = {4'h3, 4'h5, 4'hA}; vecs[3].rmode = 1; vecs[3].rconst = 4'hC; vecs[3].exp_out = 6'd12;
        vecs[4].vol = {4'h0, 4'h0, 4'hF}; vecs[4].rmode = 0; vecs[4].rconst = 4'h0; vecs[4].exp_out = 6'd0;

        for (int i = 0; i < 256; i++) rom_tab[i] = 4'($urandom_range(0, 15));

        reset = 1; tick = 0; wr_en = 0; wr_voice = 0; wr_freq = 0; wr_vol = 0; wr_wsel = 0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out", 32'(out), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_waveaddr", 32'(waveaddr), 0);
        do_reset();

        // Vector table: single pass from reset, fixed latency and known sum.
        for (int i = 0; i < 5; i++) begin
            do_reset();
            rom_mode = vecs[i].rmode; rom_const = vecs[i].rconst;
            for (int v = 0; v < NVOICE; v++) wr(3'(v), 20'h0, vecs[i].vol[v], 3'(v));
            t0 = cyc;
            do_tick();
            wait_valid(t0, lat);
            chk($sformatf("tbl%0d_latency", i), 32'(lat), NVOICE + 2);
            chk($sformatf("tbl%0d_out", i), 32'(out), 32'(vecs[i].exp_out));
            idle(2);
        end

        // Single voice address sequence across two passes.
        do_reset();
        rom_mode = 0;
        wr(3'd0, 20'h08000, 4'hF, 3'd2);
        t0 = cyc; do_tick();
        chk("sv_addr_v0", 32'(waveaddr), 32'h40); idle(1);
        chk("sv_addr_v1", 32'(waveaddr), 32'h00); idle(1);
        chk("sv_addr_v2", 32'(waveaddr), 32'h00);
        wait_valid(t0, lat);
        chk("sv_out1", 32'(out), 0);
        idle(1);
        t0 = cyc; do_tick();
        chk("sv_addr_p2", 32'(waveaddr), 32'h41);
        wait_valid(t0, lat);
        chk("sv_out2", 32'(out), 0);
        idle(2);

        // Full-scale mix: busy window and out_valid position.
        do_reset();
        rom_mode = 1; rom_const = 4'hF;
        for (int v = 0; v < NVOICE; v++) wr(3'(v), 20'h0, 4'hF, 3'd0);
        t0 = cyc; do_tick();
        for (int i = 1; i <= 6; i++) begin
            chk($sformatf("fs_busy_c%0d", i), 32'(busy), 32'(i <= 5));
            chk($sformatf("fs_valid_c%0d", i), 32'(out_valid), 32'(i == 5));
            if (i == 5) chk("fs_out", 32'(out), 42);
            idle(1);
        end

        // Overrun: second tick inside the pass is dropped and latched.
        do_reset();
        t0 = cyc; do_tick(); idle(1); do_tick();
        chk("ovr_set", 32'(overrun), 1);
        nv = 0; vc = -1;
        for (int i = 0; i < 10; i++) begin
            if (out_valid === 1'b1) begin nv++; vc = cyc - t0; end
            idle(1);
        end
        chk("ovr_nvalid", 32'(nv), 1);
        chk("ovr_vcycle", 32'(vc), 5);
        chk("ovr_sticky", 32'(overrun), 1);

        // Accumulator wrap: two passes at 0xFFFFF leave 0xFFFFE, then +2 wraps to 0.
        do_reset();
        rom_mode = 0;
        wr(3'd0, 20'hFFFFF, 4'hF, 3'd0);
        for (int p = 0; p < 2; p++) begin
            t0 = cyc; do_tick(); wait_valid(t0, lat); idle(1);
        end
        wr(3'd0, 20'h00002, 4'hF, 3'd0);
        t0 = cyc; do_tick();
        chk("wrap_addr_p3", 32'(waveaddr), 32'h1F);
        wait_valid(t0, lat);
        chk("wrap_out_p3", 32'(out), 14);
        idle(1);
        t0 = cyc; do_tick();
        chk("wrap_addr_p4", 32'(waveaddr), 32'h00);
        wait_valid(t0, lat);
        chk("wrap_out_p4", 32'(out), 0);
        idle(2);

        // Write collision: voice1 silenced during its own fetch cycle.
        do_reset();
        rom_mode = 1; rom_const = 4'hF;
        for (int v = 0; v < NVOICE; v++) wr(3'(v), 20'h0, 4'hF, 3'd0);
        t0 = cyc; do_tick(); idle(1);
        wr(3'd1, 20'h0, 4'h0, 3'd0);
        wait_valid(t0, lat);
        chk("col_out_cur", 32'(out), 42);
        idle(1);
        t0 = cyc; do_tick(); wait_valid(t0, lat);
        chk("col_out_next", 32'(out), 28);
        idle(2);

        // Mid-pass reset aborts the pass and clears everything.
        t0 = cyc; do_tick(); idle(2); do_reset();
        chk("mr_out", 32'(out), 0);
        chk("mr_valid", 32'(out_valid), 0);
        chk("mr_busy", 32'(busy), 0);
        chk("mr_waveaddr", 32'(waveaddr), 0);
        chk("mr_overrun", 32'(overrun), 0);
        idle(8);
        for (int v = 0; v < NVOICE; v++) wr(3'(v), 20'h0, 4'hF, 3'd0);
        t0 = cyc; do_tick(); wait_valid(t0, lat);
        chk("mr_latency", 32'(lat), NVOICE + 2);
        chk("mr_out_after", 32'(out), 42);
        idle(2);

        // Randomized traffic against the model, including writes to invalid voices.
        do_reset();
        rom_mode = 2;
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 99) == 0, $urandom_range(0, 99) < 20,
                 $urandom_range(0, 99) < 30, 3'($urandom_range(0, 7)),
                 20'($urandom), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
        end
        idle(8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
